// File: rtl/dis_pal_src_arbiter_pkg.sv
// Shared types for the PAL display source arbiter.
// FSM state encoding and packet-type constants.
package dis_pal_src_arbiter_pkg;

  typedef enum logic {
    ST_HUNT = 1'b0,
    ST_PASS = 1'b1
  } arb_st_e;

  localparam logic [3:0] PKT_TYPE_VIDEO = 4'h0;

endpackage

// File: rtl/dis_pal_src_arbiter_mux.sv
// 2:1 Avalon-ST beat mux with ready demux for the source arbiter.
// The unselected source receives i_idle_ready.
module dis_pal_arb_mux #(
  parameter int DW = 10
) (
  input  logic          i_sel,
  input  logic [DW-1:0] i_s0_data,
  input  logic          i_s0_valid,
  input  logic          i_s0_sop,
  input  logic          i_s0_eop,
  input  logic [DW-1:0] i_s1_data,
  input  logic          i_s1_valid,
  input  logic          i_s1_sop,
  input  logic          i_s1_eop,
  input  logic          i_ready,
  input  logic          i_idle_ready,
  output logic [DW-1:0] o_data,
  output logic          o_valid,
  output logic          o_sop,
  output logic          o_eop,
  output logic          o_s0_ready,
  output logic          o_s1_ready
);

  assign o_data  = i_sel ? i_s1_data  : i_s0_data;
  assign o_valid = i_sel ? i_s1_valid : i_s0_valid;
  assign o_sop   = i_sel ? i_s1_sop   : i_s0_sop;
  assign o_eop   = i_sel ? i_s1_eop   : i_s0_eop;

  assign o_s0_ready = i_sel ? i_idle_ready : i_ready;
  assign o_s1_ready = i_sel ? i_ready : i_idle_ready;

endmodule

// File: rtl/dis_pal_src_arbiter.sv
// Packet-boundary source arbiter feeding the PAL display chain.
// DIS_PAL_ARB_DRAIN_EN: drain the unselected source instead of holding it.
module dis_pal_src_arbiter
  import dis_pal_src_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 10,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  vst_clk,
  input  logic                  vst_rst_n,
  input  logic                  sel,
  input  logic [DATA_WIDTH-1:0] s0_data,
  input  logic                  s0_valid,
  input  logic                  s0_startofpacket,
  input  logic                  s0_endofpacket,
  output logic                  s0_ready,
  input  logic [DATA_WIDTH-1:0] s1_data,
  input  logic                  s1_valid,
  input  logic                  s1_startofpacket,
  input  logic                  s1_endofpacket,
  output logic                  s1_ready,
  output logic [DATA_WIDTH-1:0] dout_data,
  output logic                  dout_valid,
  output logic                  dout_startofpacket,
  output logic                  dout_endofpacket,
  input  logic                  dout_ready,
  output logic                  active_src,
  output logic [CNT_WIDTH-1:0]  frame_cnt
);

  arb_st_e              r_st;
  arb_st_e              w_st_nxt;
  logic                 r_sel_q;
  logic                 r_cur;
  logic                 r_is_video;
  logic [CNT_WIDTH-1:0] r_frame_cnt;

  logic [DATA_WIDTH-1:0] w_data;
  logic                  w_valid;
  logic                  w_sop;
  logic                  w_eop;
  logic                  w_ready;
  logic                  w_idle_ready;
  logic                  w_out_valid;
  logic                  w_cur_nxt;
  logic                  w_vid_ld;
  logic                  w_cnt_inc;

`ifdef DIS_PAL_ARB_DRAIN_EN
  assign w_idle_ready = vst_rst_n;
`else
  assign w_idle_ready = 1'b0;
`endif

  dis_pal_arb_mux #(
    .DW(DATA_WIDTH)
  ) u_mux (
    .i_sel       (r_cur),
    .i_s0_data   (s0_data),
    .i_s0_valid  (s0_valid),
    .i_s0_sop    (s0_startofpacket),
    .i_s0_eop    (s0_endofpacket),
    .i_s1_data   (s1_data),
    .i_s1_valid  (s1_valid),
    .i_s1_sop    (s1_startofpacket),
    .i_s1_eop    (s1_endofpacket),
    .i_ready     (w_ready & vst_rst_n),
    .i_idle_ready(w_idle_ready),
    .o_data      (w_data),
    .o_valid     (w_valid),
    .o_sop       (w_sop),
    .o_eop       (w_eop),
    .o_s0_ready  (s0_ready),
    .o_s1_ready  (s1_ready)
  );

  always_comb begin
    w_st_nxt    = r_st;
    w_out_valid = 1'b0;
    w_ready     = 1'b0;
    w_cur_nxt   = r_cur;
    w_vid_ld    = 1'b0;
    w_cnt_inc   = 1'b0;
    unique case (r_st)
      ST_HUNT: begin
        w_cur_nxt = r_sel_q;
        if (w_sop) begin
          w_out_valid = w_valid;
          w_ready     = dout_ready;
        end else begin
          w_ready = 1'b1;
        end
        // cur must not move under a packet that is just starting
        if (w_sop && w_valid && dout_ready) begin
          w_vid_ld = 1'b1;
          if (!w_eop) begin
            w_st_nxt  = ST_PASS;
            w_cur_nxt = r_cur;
          end
        end
      end
      ST_PASS: begin
        w_out_valid = w_valid;
        w_ready     = dout_ready;
        if (w_valid && dout_ready && w_eop) begin
          w_st_nxt  = ST_HUNT;
          w_cnt_inc = r_is_video;
        end
      end
    endcase
  end

  always_ff @(posedge vst_clk or negedge vst_rst_n) begin
    if (!vst_rst_n) r_st <= ST_HUNT;
    else            r_st <= w_st_nxt;
  end

  always_ff @(posedge vst_clk or negedge vst_rst_n) begin
    if (!vst_rst_n) begin
      r_sel_q     <= 1'b0;
      r_cur       <= 1'b0;
      r_is_video  <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_sel_q <= sel;
      r_cur   <= w_cur_nxt;
      if (w_vid_ld)
        r_is_video <= (w_data[3:0] == PKT_TYPE_VIDEO);
      if (w_cnt_inc)
        r_frame_cnt <= r_frame_cnt + CNT_WIDTH'(1);
    end
  end

  assign dout_data          = w_data;
  assign dout_valid         = w_out_valid & vst_rst_n;
  assign dout_startofpacket = w_sop;
  assign dout_endofpacket   = w_eop;
  assign active_src         = r_cur;
  assign frame_cnt          = r_frame_cnt;

endmodule

// File: tb/tb_dis_pal_src_arbiter.sv
// Directed bench for dis_pal_src_arbiter with a per-cycle rule model.
module tb_dis_pal_src_arbiter;

  localparam int DW = 10;
  localparam int CW = 8;
`ifdef DIS_PAL_ARB_DRAIN_EN
  localparam bit DRAIN = 1'b1;
`else
  localparam bit DRAIN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sel = 1'b0;
  logic [DW-1:0] s0_data = '0;
  logic          s0_valid = 1'b0;
  logic          s0_sop = 1'b0;
  logic          s0_eop = 1'b0;
  logic          s0_ready;
  logic [DW-1:0] s1_data = '0;
  logic          s1_valid = 1'b0;
  logic          s1_sop = 1'b0;
  logic          s1_eop = 1'b0;
  logic          s1_ready;
  logic [DW-1:0] dout_data;
  logic          dout_valid;
  logic          dout_sop;
  logic          dout_eop;
  logic          dout_ready = 1'b1;
  logic          active_src;
  logic [CW-1:0] frame_cnt;

  int n_checks = 0;
  int n_err = 0;
  logic [DW-1:0] q_out[$];

  always #5 clk = ~clk;

  dis_pal_src_arbiter #(
    .DATA_WIDTH(DW),
    .CNT_WIDTH (CW)
  ) dut (
    .vst_clk           (clk),
    .vst_rst_n         (rst_n),
    .sel               (sel),
    .s0_data           (s0_data),
    .s0_valid          (s0_valid),
    .s0_startofpacket  (s0_sop),
    .s0_endofpacket    (s0_eop),
    .s0_ready          (s0_ready),
    .s1_data           (s1_data),
    .s1_valid          (s1_valid),
    .s1_startofpacket  (s1_sop),
    .s1_endofpacket    (s1_eop),
    .s1_ready          (s1_ready),
    .dout_data         (dout_data),
    .dout_valid        (dout_valid),
    .dout_startofpacket(dout_sop),
    .dout_endofpacket  (dout_eop),
    .dout_ready        (dout_ready),
    .active_src        (active_src),
    .frame_cnt         (frame_cnt)
  );

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    n_checks++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", n, a, e, $time);
    end
  endtask

  // Model: in_pkt says a packet from owner is in flight.
  logic          m_in_pkt = 1'b0;
  logic          m_owner = 1'b0;
  logic          m_req = 1'b0;
  logic          m_video = 1'b0;
  logic [CW-1:0] m_cnt = '0;

  function automatic logic [DW-1:0] o_data();
    return m_owner ? s1_data : s0_data;
  endfunction
  function automatic logic o_v();
    return m_owner ? s1_valid : s0_valid;
  endfunction
  function automatic logic o_sop();
    return m_owner ? s1_sop : s0_sop;
  endfunction
  function automatic logic o_eop();
    return m_owner ? s1_eop : s0_eop;
  endfunction
  function automatic logic exp_valid();
    if (!rst_n) return 1'b0;
    if (m_in_pkt || o_sop()) return o_v();
    return 1'b0;
  endfunction
  function automatic logic exp_own_rdy();
    if (!rst_n) return 1'b0;
    if (m_in_pkt || o_sop()) return dout_ready;
    return 1'b1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_in_pkt <= 1'b0;
      m_owner  <= 1'b0;
      m_req    <= 1'b0;
      m_video  <= 1'b0;
      m_cnt    <= '0;
    end else begin
      logic [DW-1:0] d;
      logic xfer;
      d = o_data();
      xfer = exp_valid() && dout_ready;
      m_req <= sel;
      if (!m_in_pkt) begin
        if (xfer) m_video <= (d[3:0] == 4'h0);
        if (xfer && !o_eop()) m_in_pkt <= 1'b1;
        else m_owner <= m_req;
      end else if (xfer && o_eop()) begin
        m_in_pkt <= 1'b0;
        if (m_video) m_cnt <= m_cnt + 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    logic ev, orr, idl;
    ev  = exp_valid();
    orr = exp_own_rdy();
    idl = rst_n & DRAIN;
    chk("dout_valid", dout_valid, ev);
    if (ev) begin
      chk("dout_data", dout_data, o_data());
      chk("dout_sop", dout_sop, o_sop());
      chk("dout_eop", dout_eop, o_eop());
    end
    chk("s0_ready", s0_ready, m_owner ? idl : orr);
    chk("s1_ready", s1_ready, m_owner ? orr : idl);
    chk("active_src", active_src, m_owner);
    chk("frame_cnt", frame_cnt, m_cnt);
    if (rst_n && dout_valid && dout_ready) q_out.push_back(dout_data);
  end

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle();
    s0_valid = 1'b0; s0_sop = 1'b0; s0_eop = 1'b0;
    s1_valid = 1'b0; s1_sop = 1'b0; s1_eop = 1'b0;
  endtask

  task automatic beat(int src, logic [DW-1:0] d, logic sp, logic ep);
    logic r;
    if (src == 0) begin
      s0_data = d; s0_valid = 1'b1; s0_sop = sp; s0_eop = ep;
    end else begin
      s1_data = d; s1_valid = 1'b1; s1_sop = sp; s1_eop = ep;
    end
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      r = (src == 0) ? s0_ready : s1_ready;
      @(posedge clk);
      #1;
      if (r) return;
    end
    n_err++;
    $display("FAIL beat_timeout src=%0d data=%0h", src, d);
  endtask

  task automatic pkt(int src, logic [DW-1:0] d0, int n);
    for (int i = 0; i < n; i++)
      beat(src, d0 + DW'(i), i == 0, i == n - 1);
    idle();
  endtask

  initial begin
    int base;
    cyc(3);
    @(negedge clk);
    chk("rst_dout_valid", dout_valid, 0);
    chk("rst_s0_ready", s0_ready, 0);
    chk("rst_s1_ready", s1_ready, 0);
    chk("rst_active", active_src, 0);
    chk("rst_cnt", frame_cnt, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(2);

    // 3-beat video packet from s0
    beat(0, 10'h000, 1, 0);
    beat(0, 10'h101, 0, 0);
    beat(0, 10'h102, 0, 1);
    idle();
    chk("t1_beats", q_out.size(), 3);
    chk("t1_b0", q_out[0], 10'h000);
    chk("t1_b2", q_out[2], 10'h102);
    chk("t1_cnt", frame_cnt, 1);
    chk("t1_active", active_src, 0);

    // sel flips during a 100-beat s0 packet
    base = q_out.size();
    for (int i = 0; i < 100; i++) begin
      if (i == 1) sel = 1'b1;
      beat(0, DW'(10'h010 + i), i == 0, i == 99);
    end
    idle();
    chk("t2_beats", q_out.size() - base, 100);
    chk("t2_last", q_out[$], DW'(10'h010 + 99));
    chk("t2_active_n1", active_src, 0);
    cyc(1);
    chk("t2_active_n2", active_src, 1);
    pkt(1, 10'h000, 2);
    chk("t2_s1_b0", q_out[$-1], 10'h000);
    chk("t2_cnt", frame_cnt, 3);

    // control packet from s0
    sel = 1'b0;
    cyc(3);
    pkt(0, 10'h00F, 4);
    chk("t3_last", q_out[$], 10'h012);
    chk("t3_cnt", frame_cnt, 3);

    // non-SOP beats are dropped while hunting
    base = q_out.size();
    for (int i = 0; i < 5; i++) beat(0, DW'(10'h050 + i), 0, 0);
    pkt(0, 10'h080, 3);
    chk("t4_beats", q_out.size() - base, 3);
    chk("t4_first", q_out[base], 10'h080);
    chk("t4_cnt", frame_cnt, 4);

    // dout_ready stalls mid-packet, s1 presenting the whole time
    base = q_out.size();
    s1_valid = 1'b1;
    s1_data = 10'h3FF;
    fork
      begin
        for (int i = 0; i < 6; i++)
          beat(0, DW'(10'h200 + i), i == 0, i == 5);
        s0_valid = 1'b0; s0_sop = 1'b0; s0_eop = 1'b0;
      end
      begin
        cyc(2);
        dout_ready = 1'b1; cyc(1);
        dout_ready = 1'b0; cyc(1);
        dout_ready = 1'b0; cyc(1);
        dout_ready = 1'b1;
      end
    join
    idle();
    chk("t5_beats", q_out.size() - base, 6);
    for (int i = 0; i < 6; i++)
      chk("t5_seq", q_out[base + i], DW'(10'h200 + i));
    chk("t5_cnt", frame_cnt, 5);

    // counter wrap
    for (int i = 0; i < 250; i++) pkt(0, 10'h0A0, 2);
    chk("t6_full", frame_cnt, 8'hFF);
    pkt(0, 10'h0A0, 2);
    chk("t6_wrap", frame_cnt, 8'h00);

    // reset mid-packet
    beat(0, 10'h300, 1, 0);
    s0_data = 10'h301; s0_sop = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("t7_valid", dout_valid, 0);
    chk("t7_s0_ready", s0_ready, 0);
    cyc(2);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t7_hunt_drop", dout_valid, 0);
    chk("t7_hunt_rdy", s0_ready, 1);
    idle();
    cyc(2);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

endmodule
